// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter.
package dmem_arb_pkg;

  // Arbitration state: normal priority arbitration or debug-held ownership.
  typedef enum logic {
    ARB    = 1'b0,
    LOCKED = 1'b1
  } arb_state_e;

  // Which port a registered read return belongs to.
  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_DBG = 1'b1
  } owner_e;

  // Width of the debug starvation counter (limit range 1..15).
  localparam int STARVE_CNT_W = 4;

endpackage

// File: rtl/dmem_arb_starve_ctr.sv
// Saturating counter of consecutive cycles a debug request has been denied.
module dmem_arb_starve_ctr
  import dmem_arb_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,       // synchronous, active-low
  input  logic                    inc_i,
  input  logic                    clr_i,
  input  logic [STARVE_CNT_W-1:0] max_i,
  output logic [STARVE_CNT_W-1:0] cnt_o,
  output logic                    at_max_o
);

  logic [STARVE_CNT_W-1:0] cnt_q, cnt_d;

  // Clear wins over increment; increment stops once the limit is reached.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q < max_i)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o    = cnt_q;
  assign at_max_o = (cnt_q == max_i);

endmodule

// File: rtl/dmem_arbiter.sv
// Arbitrates the single-port data RAM between the processor and the debug
// port, with processor priority, starvation relief and debug burst locking.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int DATA_W     = 16,
  parameter int ADDR_W     = 7,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,        // synchronous, active-low
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic              dbg_gnt,
  output logic              dbg_rvalid,
  output logic [DATA_W-1:0] dbg_rdata,
  input  logic              dbg_lock,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam logic [STARVE_CNT_W-1:0] STARVE_LIMIT = STARVE_CNT_W'(STARVE_MAX);

  arb_state_e state_q, state_d;
  owner_e     owner_q;
  logic       rvalid_q;
  logic       starve_at_max;
  logic [STARVE_CNT_W-1:0] starve_cnt;

  dmem_arb_starve_ctr u_starve (
    .clk      (clk),
    .rst      (rst),
    .inc_i    (dbg_req && !dbg_gnt),
    .clr_i    (!dbg_req || dbg_gnt),
    .max_i    (STARVE_LIMIT),
    .cnt_o    (starve_cnt),
    .at_max_o (starve_at_max)
  );

  // Grant selection and next state; nothing is granted while reset is held.
  always_comb begin
    state_d = state_q;
    cpu_gnt = 1'b0;
    dbg_gnt = 1'b0;
    if (rst) begin
      case (state_q)
        ARB: begin
          if (cpu_req && !(dbg_req && starve_at_max)) begin
            cpu_gnt = 1'b1;
          end else if (dbg_req) begin
            dbg_gnt = 1'b1;
            if (dbg_lock) state_d = LOCKED;
          end
        end
        LOCKED: begin
          // Only debug may access; dropping lock releases next cycle even
          // if this final access is still being granted.
          dbg_gnt = dbg_req;
          if (!dbg_lock) state_d = ARB;
        end
        default: state_d = ARB;
      endcase
    end
  end

  // Route the winner's request fields to the RAM; idle bus is all zeros.
  always_comb begin
    mem_en    = cpu_gnt | dbg_gnt;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (cpu_gnt) begin
      mem_we    = cpu_we;
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
    end else if (dbg_gnt) begin
      mem_we    = dbg_we;
      mem_addr  = dbg_addr;
      mem_wdata = dbg_wdata;
    end
  end

  // State register plus read-return tracking (valid bit and owner tag).
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= ARB;
      rvalid_q <= 1'b0;
      owner_q  <= OWN_CPU;
    end else begin
      state_q  <= state_d;
      rvalid_q <= (cpu_gnt && !cpu_we) || (dbg_gnt && !dbg_we);
      if (cpu_gnt || dbg_gnt) begin
        owner_q <= dbg_gnt ? OWN_DBG : OWN_CPU;
      end
    end
  end

  assign cpu_rvalid = rvalid_q && (owner_q == OWN_CPU);
  assign dbg_rvalid = rvalid_q && (owner_q == OWN_DBG);
  assign cpu_rdata  = cpu_rvalid ? mem_rdata : '0;
  assign dbg_rdata  = dbg_rvalid ? mem_rdata : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Randomized scoreboard bench for dmem_arbiter with a behavioural RAM.
module tb_dmem_arbiter;

  localparam int DW   = 16;
  localparam int AW   = 7;
  localparam int SMAX = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          cpu_req, cpu_we, dbg_req, dbg_we, dbg_lock;
  logic [AW-1:0] cpu_addr, dbg_addr;
  logic [DW-1:0] cpu_wdata, dbg_wdata;
  logic          cpu_gnt, cpu_rvalid, dbg_gnt, dbg_rvalid;
  logic [DW-1:0] cpu_rdata, dbg_rdata;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;

  always #5 clk = ~clk;

  dmem_arbiter #(.DATA_W(DW), .ADDR_W(AW), .STARVE_MAX(SMAX)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata),
    .dbg_lock(dbg_lock),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  // Synchronous single-port RAM the arbiter drives.
  logic [DW-1:0] ram [128];
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      else        mem_rdata <= ram[mem_addr];
    end
  end

  // Reference model state
  typedef struct { logic [DW-1:0] data; int due; } rd_t;
  rd_t           cq[$];
  rd_t           dq[$];
  logic [DW-1:0] ref_mem [128];
  bit            m_locked;
  int            m_starve;
  int            cyc;
  bit            mon_en;
  logic          e_rn, e_cg, e_dg, e_en, e_we;
  logic [AW-1:0] e_addr;
  logic [DW-1:0] e_wdata;
  int            n_checks;
  int            n_errors;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s cyc %0d: got %h expected %h", nm, cyc, act, exp);
    end
  endtask

  // Apply current inputs for one cycle, predicting the DUT's response.
  task automatic step(input logic rn);
    rd_t item;
    rst  = rn;
    e_rn = rn;
    e_cg = 1'b0;
    e_dg = 1'b0;
    if (rn) begin
      if (m_locked)                                   e_dg = dbg_req;
      else if (cpu_req && !(dbg_req && m_starve == SMAX)) e_cg = 1'b1;
      else if (dbg_req)                               e_dg = 1'b1;
    end
    e_en = e_cg | e_dg;
    e_we = e_cg ? cpu_we : (e_dg ? dbg_we : 1'b0);
    e_addr  = e_cg ? cpu_addr  : (e_dg ? dbg_addr  : '0);
    e_wdata = e_cg ? cpu_wdata : (e_dg ? dbg_wdata : '0);
    if (e_en && e_we) ref_mem[e_addr] = e_wdata;
    if (e_en && !e_we) begin
      item.data = ref_mem[e_addr];
      item.due  = cyc + 1;
      if (e_cg) cq.push_back(item);
      else      dq.push_back(item);
    end
    if (!rn) begin
      m_locked = 0;
      m_starve = 0;
    end else begin
      m_locked = m_locked ? dbg_lock : (e_dg && dbg_lock);
      m_starve = (dbg_req && !e_dg) ? ((m_starve < SMAX) ? m_starve + 1 : SMAX) : 0;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic set_cpu(input logic r, input logic w, input int a, input logic [DW-1:0] d);
    cpu_req = r; cpu_we = w; cpu_addr = AW'(a); cpu_wdata = d;
  endtask

  task automatic set_dbg(input logic r, input logic w, input int a, input logic [DW-1:0] d, input logic l);
    dbg_req = r; dbg_we = w; dbg_addr = AW'(a); dbg_wdata = d; dbg_lock = l;
  endtask

  // Monitor: compare grants, RAM bus and read returns against expectations.
  always @(negedge clk) begin
    if (mon_en) begin
      bit ev;
      chk("cpu_gnt", 32'(cpu_gnt), 32'(e_cg));
      chk("dbg_gnt", 32'(dbg_gnt), 32'(e_dg));
      chk("mem_en",  32'(mem_en),  32'(e_en));
      if (e_en || !e_rn) begin
        chk("mem_we",    32'(mem_we),    32'(e_we));
        chk("mem_addr",  32'(mem_addr),  32'(e_addr));
        chk("mem_wdata", 32'(mem_wdata), 32'(e_wdata));
      end
      ev = (cq.size() > 0) && (cq[0].due == cyc);
      chk("cpu_rvalid", 32'(cpu_rvalid), 32'(ev));
      if (ev) begin
        if (cpu_rvalid) chk("cpu_rdata", 32'(cpu_rdata), 32'(cq[0].data));
        void'(cq.pop_front());
      end else begin
        chk("cpu_rdata_idle", 32'(cpu_rdata), 32'd0);
      end
      ev = (dq.size() > 0) && (dq[0].due == cyc);
      chk("dbg_rvalid", 32'(dbg_rvalid), 32'(ev));
      if (ev) begin
        if (dbg_rvalid) chk("dbg_rdata", 32'(dbg_rdata), 32'(dq[0].data));
        void'(dq.pop_front());
      end else begin
        chk("dbg_rdata_idle", 32'(dbg_rdata), 32'd0);
      end
    end
  end

  initial begin
    bit c_pend, d_pend;
    int cp, dp, lp;
    for (int i = 0; i < 128; i++) begin
      ram[i]     = '0;
      ref_mem[i] = '0;
    end
    n_checks = 0; n_errors = 0; cyc = 0; mon_en = 0;
    m_locked = 0; m_starve = 0;
    rst = 1'b0;
    set_cpu(0, 0, 0, 0);
    set_dbg(0, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    mon_en = 1;
    // Reset held with requests present: nothing granted, bus idle
    set_cpu(1, 1, 9, 16'hFFFF);
    set_dbg(1, 1, 8, 16'hEEEE, 1);
    step(0);
    step(0);
    set_dbg(0, 0, 0, 0, 0);
    // CPU only: write then read addr 5
    set_cpu(1, 1, 5, 16'h1234); step(1);
    set_cpu(1, 0, 5, 0);        step(1);
    set_cpu(0, 0, 0, 0);        step(1);
    // Preload and alternate routed reads
    set_cpu(1, 1, 1, 16'h0011); step(1);
    set_cpu(1, 1, 2, 16'h0022); step(1);
    for (int i = 0; i < 2; i++) begin
      set_cpu(1, 0, 1, 0); set_dbg(0, 0, 0, 0, 0); step(1);
      set_cpu(0, 0, 0, 0); set_dbg(1, 0, 2, 0, 0); step(1);
    end
    set_dbg(0, 0, 0, 0, 0); step(1);
    // Contention: both held, debug forced through after SMAX denials
    set_cpu(1, 0, 5, 0); set_dbg(1, 0, 1, 0, 0);
    repeat (8) step(1);
    set_cpu(0, 0, 0, 0); set_dbg(0, 0, 0, 0, 0); step(1);
    // Lock burst of four debug writes, CPU waiting from the second cycle
    for (int i = 0; i < 4; i++) begin
      set_dbg(1, 1, i, DW'(16'hA000 + i), (i != 3));
      set_cpu((i > 0), 0, 0, 0);
      step(1);
    end
    set_dbg(0, 0, 0, 0, 0); set_cpu(1, 0, 0, 0); step(1);
    set_cpu(0, 0, 0, 0);
    for (int i = 1; i < 4; i++) begin
      set_dbg(1, 0, i, 0, 0); step(1);
    end
    // Reset while LOCKED with a read in flight, then CPU granted at once
    set_dbg(1, 0, 3, 0, 1); step(1);
    set_dbg(1, 0, 2, 0, 1); set_cpu(1, 0, 5, 0); step(1);
    step(0);
    set_dbg(0, 0, 0, 0, 0); step(1);
    // Idle
    set_cpu(0, 0, 0, 0);
    repeat (4) step(1);
    // Randomized traffic honoring hold-until-granted
    c_pend = 0; d_pend = 0;
    for (int k = 0; k < 3000; k++) begin
      cp = (k < 1000) ? 90 : ((k < 2000) ? 40 : 70);
      dp = (k < 1000) ? 90 : ((k < 2000) ? 60 : 30);
      lp = (k < 1000) ? 20 : ((k < 2000) ? 70 : 40);
      if (!c_pend && ($urandom_range(99) < cp)) begin
        c_pend = 1;
        set_cpu(1, 1'($urandom_range(1)), $urandom_range(15), DW'($urandom));
      end
      cpu_req = c_pend;
      if (!d_pend && ($urandom_range(99) < dp)) begin
        d_pend = 1;
        set_dbg(1, 1'($urandom_range(1)), $urandom_range(15), DW'($urandom), 1'b0);
      end
      dbg_req  = d_pend;
      dbg_lock = ($urandom_range(99) < lp);
      step(($urandom_range(199) != 0) ? 1'b1 : 1'b0);
      if (e_cg) c_pend = 0;
      if (e_dg) d_pend = 0;
    end
    set_cpu(0, 0, 0, 0);
    set_dbg(0, 0, 0, 0, 0);
    repeat (3) step(1);
    chk("drain", 32'(cq.size() + dq.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
